// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream boot loader that fills instruction memory and releases the core
module im_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           part_q, part_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic        xfer;
    logic [15:0] new_len;
    logic        len_ok;
    logic        last_word;

    // ready_q mirrors the registered state, so a transfer is fully determined by registers
    assign xfer      = byte_valid & ready_q;
    assign new_len   = {len_q[15:8], byte_data};
    assign len_ok    = (new_len != 16'd0) && ({17'd0, new_len} <= MAX_WORDS);
    assign last_word = (33'(idx_q) + 33'd1) == 33'(len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        part_d  = part_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    err_d   = 2'b00;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    bcnt_d  = 2'd0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_data, 8'h00};
                    csum_d  = csum_q ^ byte_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d  = new_len;
                    csum_d = csum_q ^ byte_data;
                    if (len_ok) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'b01;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = {part_q, byte_data};
                        idx_d   = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        part_d = {part_q[15:0], byte_data};
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'b10;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            idx_q   <= '0;
            bcnt_q  <= 2'd0;
            part_q  <= 24'd0;
            csum_q  <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 2'b00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            part_q  <= part_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign byte_ready = ready_q;
    assign busy       = ready_q;
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign done       = done_q;
    assign cpu_rst    = done_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - self-checking bench for im_loader against a frame-level reference model
module tb_im_loader;

    localparam int AW   = 10;
    localparam int MAXW = 1 << AW;
    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_ELEN  = 2;
    localparam int ST_ECSUM = 3;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;

    im_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the session is just the list of accepted bytes; everything follows from it
    logic [7:0]    m_got[$];
    bit            m_sess = 1'b0;
    int            m_stat = ST_BUSY;
    bit            m_xfer = 1'b0;
    bit            chk_en = 1'b0;
    bit            e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_wdata = 32'd0;
    bit            e_busy = 1'b0;
    bit            e_done = 1'b0;
    logic [1:0]    e_err = 2'd0;

    function automatic int frame_status();
        int n;
        logic [7:0] x;
        if (m_got.size() < 2) return ST_BUSY;
        n = int'({m_got[0], m_got[1]});
        if (n == 0 || n > MAXW) return ST_ELEN;
        if (m_got.size() < 3 + 4 * n) return ST_BUSY;
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ m_got[i];
        return (x == m_got[2 + 4 * n]) ? ST_DONE : ST_ECSUM;
    endfunction

    always @(posedge clk) begin
        int k;
        int n;
        m_xfer = 1'b0;
        e_we   = 1'b0;
        if (!rst) begin
            m_sess = 1'b0;
            m_got.delete();
            m_stat = ST_BUSY;
            chk_en = 1'b1;
        end else if (m_sess && m_stat == ST_BUSY) begin
            if (byte_valid) begin
                m_got.push_back(byte_data);
                m_xfer = 1'b1;
                k = m_got.size();
                if (k > 2) begin
                    n = int'({m_got[0], m_got[1]});
                    if (k <= 2 + 4 * n && (k - 2) % 4 == 0) begin
                        e_we    = 1'b1;
                        e_addr  = AW'((k - 2) / 4 - 1);
                        e_wdata = {m_got[k-4], m_got[k-3], m_got[k-2], m_got[k-1]};
                    end
                end
                m_stat = frame_status();
            end
        end else if (start) begin
            m_sess = 1'b1;
            m_got.delete();
            m_stat = ST_BUSY;
        end
        e_busy = m_sess && (m_stat == ST_BUSY);
        e_done = m_sess && (m_stat == ST_DONE);
        e_err  = !m_sess ? 2'd0 : (m_stat == ST_ELEN) ? 2'd1 : (m_stat == ST_ECSUM) ? 2'd2 : 2'd0;
    end

    int wlog_addr[$];
    logic [31:0] wlog_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("byte_ready", 64'(byte_ready), 64'(e_busy));
            check("busy", 64'(busy), 64'(e_busy));
            check("done", 64'(done), 64'(e_done));
            check("cpu_rst", 64'(cpu_rst), 64'(e_done));
            check("err_code", 64'(err_code), 64'(e_err));
            check("im_we", 64'(im_we), 64'(e_we));
            if (e_we) begin
                check("im_addr", 64'(im_addr), 64'(e_addr));
                check("im_wdata", 64'(im_wdata), 64'(e_wdata));
            end
        end
        if (im_we === 1'b1) begin
            wlog_addr.push_back(int'(im_addr));
            wlog_data.push_back(im_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every third cycle, 2: random gaps
    task automatic send(input bq_t q, input int mode);
        int i = 0;
        int cyc = 0;
        while (i < q.size() && cyc < 20000) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (cyc % 3 == 0);
                default: byte_valid = ($urandom_range(1) == 1);
            endcase
            byte_data = byte_valid ? q[i] : 8'($urandom);
            tick();
            cyc++;
            if (m_xfer) i++;
        end
        byte_valid = 1'b0;
        if (i < q.size()) check("send_timeout", 64'(i), 64'(q.size()));
    endtask

    function automatic bq_t make_frame(input int n, input bit bad_csum);
        bq_t f;
        logic [7:0] x;
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        if (n >= 1 && n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
            x = 8'h00;
            foreach (f[i]) x = x ^ f[i];
            if (bad_csum) x = x ^ 8'($urandom_range(255, 1));
            f.push_back(x);
        end
        return f;
    endfunction

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    bq_t good;
    bq_t bad;
    bq_t part;
    bq_t rest;
    bq_t f;

    initial begin
        good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h01, 8'h06};
        bad  = good;
        bad[10] = 8'h07;

        // reset held for two cycles
        tick();
        tick();
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_addr", 64'(im_addr), 64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_code), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        repeat (10) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_cpu_rst", 64'(cpu_rst), 64'd0);

        // good load
        clear_log();
        do_start();
        send(good, 0);
        check("good_done", 64'(done), 64'd1);
        check("good_cpu_rst", 64'(cpu_rst), 64'd1);
        check("good_busy", 64'(busy), 64'd0);
        check("good_nwr", 64'(wlog_addr.size()), 64'd2);
        if (wlog_addr.size() == 2) begin
            check("good_a0", 64'(wlog_addr[0]), 64'd0);
            check("good_d0", 64'(wlog_data[0]), 64'h20080005);
            check("good_a1", 64'(wlog_addr[1]), 64'd1);
            check("good_d1", 64'(wlog_data[1]), 64'h21090001);
        end

        // start in DONE drops cpu_rst next cycle, then checksum error
        clear_log();
        do_start();
        check("restart_cpu_rst", 64'(cpu_rst), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        send(bad, 0);
        check("csum_err", 64'(err_code), 64'd2);
        check("csum_done", 64'(done), 64'd0);
        check("csum_cpu_rst", 64'(cpu_rst), 64'd0);
        check("csum_nwr", 64'(wlog_addr.size()), 64'd2);

        // length errors
        clear_log();
        do_start();
        send('{8'h00, 8'h00}, 0);
        check("len0_err", 64'(err_code), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        do_start();
        send('{8'h04, 8'h01}, 2);
        check("len1025_err", 64'(err_code), 64'd1);
        tick();
        check("len_nwr", 64'(wlog_addr.size()), 64'd0);

        // exactly full memory
        clear_log();
        f = make_frame(MAXW, 1'b0);
        do_start();
        send(f, 0);
        check("full_done", 64'(done), 64'd1);
        check("full_nwr", 64'(wlog_addr.size()), 64'(MAXW));
        if (wlog_addr.size() > 0) begin
            check("full_last_addr", 64'(wlog_addr[$]), 64'(MAXW - 1));
            check("full_last_data", 64'(wlog_data[$]), 64'({f[f.size()-5], f[f.size()-4], f[f.size()-3], f[f.size()-2]}));
        end

        // flow control: valid every third cycle
        clear_log();
        do_start();
        send(good, 1);
        check("fc_done", 64'(done), 64'd1);
        check("fc_nwr", 64'(wlog_addr.size()), 64'd2);
        if (wlog_data.size() == 2) check("fc_d1", 64'(wlog_data[1]), 64'h21090001);

        // reset after five bytes abandons the session without a write
        clear_log();
        part = good[0:4];
        do_start();
        send(part, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_nwr", 64'(wlog_addr.size()), 64'd0);
        do_start();
        send(good, 0);
        check("midrst_reload_done", 64'(done), 64'd1);

        // start while busy is ignored
        clear_log();
        part = good[0:3];
        rest = good[4:10];
        do_start();
        send(part, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(rest, 2);
        check("busy_start_done", 64'(done), 64'd1);
        check("busy_start_nwr", 64'(wlog_addr.size()), 64'd2);

        // randomized frames
        for (int it = 0; it < 30; it++) begin
            int n;
            int r;
            r = int'($urandom_range(9));
            if (r == 0) n = 0;
            else if (r == 1) n = int'($urandom_range(65535, MAXW + 1));
            else n = int'($urandom_range(6, 1));
            f = make_frame(n, ($urandom_range(3) == 0));
            do_start();
            send(f, int'($urandom_range(2)));
            repeat (int'($urandom_range(3))) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
